// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the multicycle datapath: radix-2 shift-add
// multiply and restoring divide on magnitudes, with a final sign-correction step.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX} stateT;

   stateT              state, nextState;
   logic [CW-1:0]      counter;
   logic [1:0]         opReg;
   logic               signA, signB;
   logic [WIDTH-1:0]   operand;
   logic [2*WIDTH-1:0] acc, accStep;
   logic               accept, divZeroHit, finish;
   logic               signedIn;
   logic [WIDTH-1:0]   magA, magB;
   logic [WIDTH:0]     addSum, shifted, remDiff;
   logic               fits;
   logic               negResult, negRemainder;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quotient, remainder;

   assign busy = (state != IDLE);

   // State register; reset discards any operation in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Next-state logic; a divide by zero finishes from IDLE without iterating.
   always_comb begin
      nextState  = state;
      accept     = 1'b0;
      divZeroHit = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (op[1] && (b == '0)) begin
                  divZeroHit = 1'b1;
               end else begin
                  accept    = 1'b1;
                  nextState = CALC;
               end
            end
         end
         CALC: begin
            if (counter == CW'(WIDTH - 1)) nextState = FIX;
         end
         FIX: begin
            finish    = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Operands are reduced to magnitudes up front so both iterations are unsigned.
   always_comb begin
      signedIn = ~op[0];
      magA     = (signedIn && a[WIDTH-1]) ? -a : a;
      magB     = (signedIn && b[WIDTH-1]) ? -b : b;
   end

   // One iteration. Multiply keeps {partial product, remaining multiplier bits} in acc;
   // divide keeps {partial remainder, dividend bits shifting into quotient bits}.
   always_comb begin
      addSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      fits    = (shifted >= {1'b0, operand});
      remDiff = shifted - {1'b0, operand};
      if (opReg[1]) begin
         accStep = {(fits ? remDiff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], fits};
      end else begin
         accStep = {addSum, acc[WIDTH-1:1]};
      end
   end

   // Sign correction: remainder follows the dividend, so division truncates toward zero.
   always_comb begin
      negResult    = ~opReg[0] && (signA ^ signB);
      negRemainder = ~opReg[0] && signA;
      product      = negResult ? -acc : acc;
      quotient     = negResult ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      remainder    = negRemainder ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   // Datapath registers; hi/lo are only written when an operation completes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         counter  <= '0;
         opReg    <= 2'b00;
         signA    <= 1'b0;
         signB    <= 1'b0;
         operand  <= '0;
         acc      <= '0;
      end else begin
         done <= finish || divZeroHit;
         if (divZeroHit) div_zero <= 1'b1;
         if (accept) begin
            opReg    <= op;
            signA    <= signedIn && a[WIDTH-1];
            signB    <= signedIn && b[WIDTH-1];
            operand  <= op[1] ? magB : magA;
            acc      <= {{WIDTH{1'b0}}, (op[1] ? magA : magB)};
            counter  <= '0;
            div_zero <= 1'b0;
         end else if (state == CALC) begin
            acc     <= accStep;
            counter <= counter + 1'b1;
         end
         if (finish) begin
            if (opReg[1]) begin
               hi <= remainder;
               lo <= quotient;
            end else begin
               hi <= product[2*WIDTH-1:WIDTH];
               lo <= product[WIDTH-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: a 32-bit instance for the main sequence and
// an 8-bit instance for narrow-width corner cases.
module tb_muldiv_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic [31:0] hi, lo;
   logic        busy, done, divZero;

   logic        start8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8;
   logic [7:0]  hi8, lo8;
   logic        busy8, done8, divZero8;

   int vectors     = 0;
   int miscompares = 0;
   int cycles, busyLow;
   logic doneSeen;

   always #5 clock = ~clock;

   muldiv_unit #(.WIDTH(32)) dut32 (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(divZero)
   );

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
      .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_zero(divZero8)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one start pulse from the current time; returns just after the accepting edge.
   task automatic applyStimulus(input logic [1:0] opV, input logic [31:0] aV, input logic [31:0] bV);
      start = 1'b1;
      op    = opV;
      a     = aV;
      b     = bV;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   // Counts edges after the start edge until done, also counting idle samples before done.
   task automatic waitDone(output int nCycles, output int nBusyLow);
      nCycles  = 0;
      nBusyLow = 0;
      while (!done && nCycles < 200) begin
         if (!busy) nBusyLow++;
         @(posedge clock);
         #1;
         nCycles++;
      end
   endtask

   task automatic run8(input logic [1:0] opV, input logic [7:0] aV, input logic [7:0] bV, output int nCycles);
      @(negedge clock);
      start8 = 1'b1;
      op8    = opV;
      a8     = aV;
      b8     = bV;
      @(posedge clock);
      #1;
      start8  = 1'b0;
      nCycles = 0;
      while (!done8 && nCycles < 100) begin
         @(posedge clock);
         #1;
         nCycles++;
      end
   endtask

   task automatic runOp(input string tag, input logic [1:0] opV, input logic [31:0] aV, input logic [31:0] bV,
                        input logic [31:0] expHi, input logic [31:0] expLo);
      @(negedge clock);
      applyStimulus(opV, aV, bV);
      waitDone(cycles, busyLow);
      checkOutput({tag, " latency"}, 64'(cycles), 64'd33);
      checkOutput({tag, " hi"}, 64'(hi), 64'(expHi));
      checkOutput({tag, " lo"}, 64'(lo), 64'(expLo));
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      op     = 2'b00;
      a      = '0;
      b      = '0;
      start8 = 1'b0;
      op8    = 2'b00;
      a8     = '0;
      b8     = '0;
      #12;
      checkOutput("reset hi", 64'(hi), 64'd0);
      checkOutput("reset lo", 64'(lo), 64'd0);
      checkOutput("reset flags", {61'd0, busy, done, divZero}, 64'd0);
      @(negedge clock);
      reset = 1'b0;

      // Signed multiply with busy/done timing checks.
      runOp("mult -3*7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      checkOutput("mult busy gap", 64'(busyLow), 64'd0);
      checkOutput("mult busy at done", 64'(busy), 64'd0);
      @(posedge clock);
      #1;
      checkOutput("done pulse width", 64'(done), 64'd0);

      runOp("multu ffffffff*2", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
      runOp("mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
      runOp("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      runOp("div overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      runOp("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

      // Divide by zero finishes from IDLE and leaves hi/lo alone.
      @(negedge clock);
      applyStimulus(2'b11, 32'd55, 32'd0);
      waitDone(cycles, busyLow);
      checkOutput("divzero latency", 64'(cycles), 64'd0);
      checkOutput("divzero flag", 64'(divZero), 64'd1);
      checkOutput("divzero hi held", 64'(hi), 64'd2);
      checkOutput("divzero lo held", 64'(lo), 64'd14);
      @(posedge clock);
      #1;
      checkOutput("divzero done drop", 64'(done), 64'd0);
      checkOutput("divzero flag sticky", 64'(divZero), 64'd1);

      @(negedge clock);
      applyStimulus(2'b01, 32'd3, 32'd3);
      checkOutput("divzero cleared", 64'(divZero), 64'd0);
      waitDone(cycles, busyLow);
      checkOutput("multu 3*3 latency", 64'(cycles), 64'd33);
      checkOutput("multu 3*3 lo", 64'(lo), 64'd9);

      // Start while busy is ignored; reset mid-calculation aborts without done.
      @(negedge clock);
      applyStimulus(2'b00, 32'h0000_1234, 32'h0000_5678);
      doneSeen = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(posedge clock);
         #1;
         if (done) doneSeen = 1'b1;
         if (cyc == 10) begin
            start = 1'b1;
            a     = 32'd99;
            b     = 32'd77;
         end else begin
            start = 1'b0;
         end
      end
      checkOutput("busy before abort", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      checkOutput("abort lo", 64'(lo), 64'd0);
      checkOutput("abort flags", {61'd0, busy, done, divZero}, 64'd0);
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(posedge clock);
         #1;
         if (done) doneSeen = 1'b1;
      end
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      if (done) doneSeen = 1'b1;
      checkOutput("abort no done", 64'(doneSeen), 64'd0);
      checkOutput("abort idle", 64'(busy), 64'd0);
      runOp("multu 5*6", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30);

      // Back-to-back: next op launched in the done cycle.
      runOp("multu 2^16*2^16", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0);
      applyStimulus(2'b10, 32'hFFFF_FF9C, 32'd7);
      checkOutput("b2b done drop", 64'(done), 64'd0);
      checkOutput("b2b busy", 64'(busy), 64'd1);
      waitDone(cycles, busyLow);
      checkOutput("b2b latency", 64'(cycles), 64'd33);
      checkOutput("b2b hi", 64'(hi), 64'hFFFF_FFFE);
      checkOutput("b2b lo", 64'(lo), 64'hFFFF_FFF2);

      // Narrow instance.
      run8(2'b10, 8'h80, 8'd3, cycles);
      checkOutput("w8 div latency", 64'(cycles), 64'd9);
      checkOutput("w8 div lo", 64'(lo8), 64'hD6);
      checkOutput("w8 div hi", 64'(hi8), 64'hFE);
      run8(2'b00, 8'hFD, 8'd7, cycles);
      checkOutput("w8 mult latency", 64'(cycles), 64'd9);
      checkOutput("w8 mult hi", 64'(hi8), 64'hFF);
      checkOutput("w8 mult lo", 64'(lo8), 64'hEB);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
